// File: rtl/c64_bus_pkg.sv
// Shared types and constants for the C64 CPU bus responder.
package c64_bus_pkg;

  typedef enum logic [1:0] {CLEAR, RUN, HOST} bus_state_t;

  localparam logic [15:0] PORT_DDR_ADDR  = 16'h0000;
  localparam logic [15:0] PORT_DATA_ADDR = 16'h0001;
  localparam logic [7:0]  PORT_DDR_RST   = 8'h00;
  localparam logic [7:0]  PORT_DATA_RST  = 8'h37;

endpackage

// File: rtl/c64_cpu_port.sv
// 6510 processor port: DDR and DATA registers, pin read mux and registered bank lines.
module c64_cpu_port
  import c64_bus_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ddr_we_i,
  input  logic       data_we_i,
  input  logic [7:0] wdata_i,
  input  logic [7:0] port_in_i,
  output logic [7:0] ddr_o,
  output logic [7:0] data_rd_o,
  output logic [2:0] bank_o
);

  logic [7:0] ddr_q, ddr_d;
  logic [7:0] data_q, data_d;
  logic [7:0] bank_full_d;
  logic [2:0] bank_q;

  always_comb begin
    ddr_d       = ddr_we_i  ? wdata_i : ddr_q;
    data_d      = data_we_i ? wdata_i : data_q;
    // Inputs (DDR=0) read as pulled high, so undriven bank lines select ROM/IO.
    bank_full_d = data_d | ~ddr_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ddr_q  <= PORT_DDR_RST;
      data_q <= PORT_DATA_RST;
      bank_q <= 3'b111;
    end else begin
      ddr_q  <= ddr_d;
      data_q <= data_d;
      bank_q <= bank_full_d[2:0];
    end
  end

  assign ddr_o     = ddr_q;
  assign data_rd_o = (data_q & ddr_q) | (port_in_i & ~ddr_q);
  assign bank_o    = bank_q;

endmodule

// File: rtl/c64_bus_responder.sv
// Memory-side responder for the 6502 core: RAM with post-reset clear and host preload.
// Define C64_CPU_PORT_EN to map the 6510 processor port at $0000/$0001.
module c64_bus_responder
  import c64_bus_pkg::*;
#(
  parameter int         AW        = 16,
  parameter logic [7:0] CLEAR_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ab,
  input  logic [7:0]  cpu_dout,
  input  logic        we,
  output logic [7:0]  cpu_din,
  output logic        cpu_hold,
  input  logic        host_sel,
  input  logic        load_valid,
  input  logic [15:0] load_addr,
  input  logic [7:0]  load_data,
  output logic        load_ready,
  output logic [15:0] load_count,
  input  logic [7:0]  port_in,
  output logic [2:0]  bank
);

  localparam int            DEPTH   = 1 << AW;
  localparam logic [AW-1:0] CNT_ONE = AW'(1);

  logic [7:0]    mem [DEPTH];
  bus_state_t    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [15:0]   count_q, count_d;

  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [7:0]    mem_wd;
  logic [7:0]    ram_rd;
  logic          cpu_wr, host_wr;
  logic          cpu_port_hit, host_port_hit;
  logic          unused_bits;

  assign unused_bits = ^{port_in, ab, load_addr};

  // Reset gates every write so a beat or CPU store on the reset cycle is lost.
  assign cpu_wr  = !reset && (state_q == RUN)  && we;
  assign host_wr = !reset && (state_q == HOST) && load_valid;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    count_d    = count_q;
    cpu_hold   = 1'b1;
    load_ready = 1'b0;
    unique case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == '1) state_d = host_sel ? HOST : RUN;
      end
      RUN: begin
        cpu_hold = 1'b0;
        if (host_sel) begin
          state_d = HOST;
          count_d = '0;
        end
      end
      HOST: begin
        load_ready = 1'b1;
        if (load_valid) count_d = count_q + 16'd1;
        if (!host_sel) state_d = RUN;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  assign load_count = count_q;

  // Single RAM write port; the state decides who owns it.
  always_comb begin
    mem_we = 1'b0;
    mem_wa = cnt_q;
    mem_wd = CLEAR_VAL;
    if (!reset && state_q == CLEAR) begin
      mem_we = 1'b1;
    end else if (cpu_wr && !cpu_port_hit) begin
      mem_we = 1'b1;
      mem_wa = ab[AW-1:0];
      mem_wd = cpu_dout;
    end else if (host_wr && !host_port_hit) begin
      mem_we = 1'b1;
      mem_wa = load_addr[AW-1:0];
      mem_wd = load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_wa] <= mem_wd;
  end

  assign ram_rd = mem[ab[AW-1:0]];

`ifdef C64_CPU_PORT_EN
  logic       ddr_we, data_we;
  logic [7:0] port_wdata, port_ddr, port_rd;

  // Full 16-bit compare: the port does not mirror through the RAM alias.
  assign cpu_port_hit  = (ab == PORT_DDR_ADDR) || (ab == PORT_DATA_ADDR);
  assign host_port_hit = (load_addr == PORT_DDR_ADDR) || (load_addr == PORT_DATA_ADDR);
  assign ddr_we  = (cpu_wr && ab == PORT_DDR_ADDR)  || (host_wr && load_addr == PORT_DDR_ADDR);
  assign data_we = (cpu_wr && ab == PORT_DATA_ADDR) || (host_wr && load_addr == PORT_DATA_ADDR);
  assign port_wdata = cpu_wr ? cpu_dout : load_data;

  c64_cpu_port u_port (
    .clk       (clk),
    .reset     (reset),
    .ddr_we_i  (ddr_we),
    .data_we_i (data_we),
    .wdata_i   (port_wdata),
    .port_in_i (port_in),
    .ddr_o     (port_ddr),
    .data_rd_o (port_rd),
    .bank_o    (bank)
  );

  always_comb begin
    cpu_din = ram_rd;
    if (ab == PORT_DDR_ADDR)       cpu_din = port_ddr;
    else if (ab == PORT_DATA_ADDR) cpu_din = port_rd;
  end
`else
  assign cpu_port_hit  = 1'b0;
  assign host_port_hit = 1'b0;
  assign cpu_din       = ram_rd;
  assign bank          = 3'b111;
`endif

endmodule

// File: tb/tb_c64_bus_responder.sv
// Directed self-checking bench for c64_bus_responder (AW=8, so RAM mirrors every 256 bytes).
module tb_c64_bus_responder;

  logic        clk = 1'b0;
  logic        reset, we, host_sel, load_valid;
  logic [15:0] ab, load_addr;
  logic [7:0]  cpu_dout, load_data, port_in;
  logic [7:0]  cpu_din;
  logic        cpu_hold, load_ready;
  logic [15:0] load_count;
  logic [2:0]  bank;

  int tests = 0;
  int fails = 0;
  int n;
  int bad;
  logic [7:0] pre [6];

  c64_bus_responder #(.AW(8), .CLEAR_VAL(8'h00)) dut (
    .clk(clk), .reset(reset), .ab(ab), .cpu_dout(cpu_dout), .we(we),
    .cpu_din(cpu_din), .cpu_hold(cpu_hold), .host_sel(host_sel),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(load_ready), .load_count(load_count), .port_in(port_in), .bank(bank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic count_hold(output int cyc);
    cyc = 0;
    while (cpu_hold === 1'b1 && cyc < 1000) begin
      cyc++;
      step();
    end
  endtask

  task automatic rd(input logic [15:0] a);
    ab = a;
    #1;
  endtask

  initial begin
    pre[0] = 8'hA2; pre[1] = 8'h20; pre[2] = 8'hA1;
    pre[3] = 8'h40; pre[4] = 8'h81; pre[5] = 8'h60;
    reset = 1'b1; we = 1'b0; host_sel = 1'b0; load_valid = 1'b0;
    ab = '0; load_addr = '0; cpu_dout = '0; load_data = '0; port_in = 8'hFF;
    step();
    check("rst_hold",  cpu_hold, 1);
    check("rst_ready", load_ready, 0);
    check("rst_count", load_count, 0);
    check("rst_bank",  bank, 3'b111);

    reset = 1'b0;
    count_hold(n);
    check("clear_cycles", n, 256);
    check("run_hold", cpu_hold, 0);

    bad = 0;
    for (int a = 0; a < 256; a++) begin
      rd(16'(a));
`ifdef C64_CPU_PORT_EN
      if (a >= 2 && cpu_din !== 8'h00) bad++;
`else
      if (cpu_din !== 8'h00) bad++;
`endif
    end
    check("clear_all_zero", bad, 0);

    // CPU write then same-address read
    ab = 16'h0324; cpu_dout = 8'h77; we = 1'b1;
    step();
    we = 1'b0;
    rd(16'h0324);
    check("cpu_wr_rd", cpu_din, 8'h77);
    ab = 16'h0050; cpu_dout = 8'h99;
    step();
    rd(16'h0050);
    check("no_we_no_write", cpu_din, 8'h00);
    ab = 16'h1324; cpu_dout = 8'h42; we = 1'b1;
    step();
    we = 1'b0;
    rd(16'h0324);
    check("mirror", cpu_din, 8'h42);

    load_valid = 1'b1; load_addr = 16'h0007; load_data = 8'hEE;
    step();
    load_valid = 1'b0;
    rd(16'h0007);
    check("run_ignores_host", cpu_din, 8'h00);

    // Host preload with idle gaps and an ignored CPU write
    host_sel = 1'b1;
    step();
    check("host_ready", load_ready, 1);
    check("host_hold",  cpu_hold, 1);
    check("host_count0", load_count, 0);
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1; load_addr = 16'(i); load_data = pre[i];
      step();
      load_valid = 1'b0;
      step();
    end
    ab = 16'h0002; cpu_dout = 8'hFF; we = 1'b1;
    step();
    we = 1'b0;
    check("host_count6", load_count, 6);
    host_sel = 1'b0; load_valid = 1'b1; load_addr = 16'h0006; load_data = 8'h5A;
    #1;
    check("hold_before_exit", cpu_hold, 1);
    step();
    load_valid = 1'b0;
    check("hold_falls", cpu_hold, 0);
    check("exit_beat_count", load_count, 7);
    rd(16'h0006);
    check("exit_beat_data", cpu_din, 8'h5A);
    rd(16'h0002);
    check("mem2_preload", cpu_din, 8'hA1);
    rd(16'h0005);
    check("mem5_preload", cpu_din, 8'h60);

    // Processor port writes
    ab = 16'h0000; cpu_dout = 8'h2F; we = 1'b1;
    step();
    ab = 16'h0001; cpu_dout = 8'h35;
    step();
    we = 1'b0;
    step();
    rd(16'h0000);
    check("port_rd0", cpu_din, 8'h2F);
`ifdef C64_CPU_PORT_EN
    rd(16'h0001);
    check("port_rd1", cpu_din, 8'hF5);
    check("port_bank", bank, 3'b101);
    rd(16'h0100);
    check("port_no_mirror", cpu_din, 8'h00);
`else
    rd(16'h0001);
    check("port_rd1", cpu_din, 8'h35);
    check("port_bank", bank, 3'b111);
    rd(16'h0100);
    check("port_no_mirror", cpu_din, 8'h2F);
`endif

    // Re-entry clears load_count, then reset mid-HOST discards the beat
    host_sel = 1'b1;
    step();
    check("reentry_count0", load_count, 0);
    load_valid = 1'b1; load_addr = 16'h0020; load_data = 8'h11;
    step();
    check("reentry_count1", load_count, 1);
    reset = 1'b1; load_addr = 16'h0010; load_data = 8'h55;
    step();
    check("rst_host_ready", load_ready, 0);
    check("rst_host_count", load_count, 0);
    check("rst_host_hold",  cpu_hold, 1);
    reset = 1'b0; load_valid = 1'b0; host_sel = 1'b0;

    // Reset mid-CLEAR restarts the full clear
    repeat (50) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    count_hold(n);
    check("reclear_cycles", n, 256);
    rd(16'h0010);
    check("discarded_beat", cpu_din, 8'h00);
    rd(16'h0324);
    check("reclear_data", cpu_din, 8'h00);
    check("reclear_ready", load_ready, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/c64_bus_responder.md
Name: c64_bus_responder

Overview:
- Memory-side responder for the `_6502` core bus: drives `cpu_din` from the address on `ab` and commits `cpu_dout` on clock edges when `we` is high.
- Replaces the behavioural RAM array used on benches with a synthesizable block that clears RAM after reset.
- Provides a host preload port for loading programs, with the CPU held off while loading.
- Optionally implements the 6510 processor port at $0000/$0001.
- Sits between the CPU and the future ROM/IO decode in the C64 top level.

Parameters:
- AW, 16: RAM address width. Depth is 2^AW. Bits `ab[15:AW]` are ignored, so RAM mirrors.
- CLEAR_VAL, 8'h00: byte written to every location during the post-reset clear.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ab  in  16  CPU address bus.
- cpu_dout  in  8  CPU write data.
- we  in  1  CPU write enable; high means write `cpu_dout` to `ab`.
- cpu_din  out  8  read data to the CPU; combinational from `ab`.
- cpu_hold  out  1  high while the CPU must be held in reset (CLEAR or HOST).
- host_sel  in  1  host requests preload mode.
- load_valid  in  1  host beat valid.
- load_addr  in  16  host beat address.
- load_data  in  8  host beat data.
- load_ready  out  1  responder accepts a beat this cycle.
- load_count  out  16  beats accepted since the last entry to HOST.
- port_in  in  8  external pins for the processor port.
- bank  out  3  {CHAREN, HIRAM, LORAM} from the processor port.

Behaviour:
- States: CLEAR, RUN, HOST. Reset has priority over everything.
- On the reset cycle, the next state is CLEAR, the clear counter is 0, `load_count` is 0, the port DDR is 8'h00 and the port DATA is 8'h37.
- Output values at and after reset: `cpu_hold`=1, `load_ready`=0, `load_count`=0, `bank`=3'b111. `cpu_din` is an unregistered read.
- CLEAR:
  - Each cycle writes CLEAR_VAL to `mem[cnt]` and increments `cnt`.
  - After the write of address 2^AW-1 (2^AW cycles), go to HOST if `host_sel` is high, else RUN.
  - `host_sel` and `load_valid` are ignored while in CLEAR.
- RUN:
  - `cpu_hold`=0.
  - `cpu_din` = `mem[ab[AW-1:0]]`, combinational, same cycle.
  - When `we`=1, `mem[ab]` <= `cpu_dout` at the edge. A read of the same address on the next cycle returns the new data.
  - `host_sel`=1 goes to HOST next cycle and clears `load_count` to 0.
- HOST:
  - `cpu_hold`=1 and `load_ready`=1 (Moore output).
  - A beat transfers when `load_valid` and `load_ready` are both high: `mem[load_addr[AW-1:0]]` <= `load_data`, and `load_count` increments, wrapping at 16 bits.
  - CPU writes are ignored.
  - When `host_sel`=0, go to RUN next cycle. A beat presented in that same cycle is still accepted.
- Reset mid-CLEAR restarts the clear at address 0.
- Reset mid-HOST: a beat presented on the reset cycle is discarded, and the next state is CLEAR.
- No contention is possible, because CPU and host writes are mutually exclusive by state.

Optional Feature:
- Macro: C64_CPU_PORT_EN.
- With the macro defined:
  - Address $0000 is the DDR and $0001 is DATA. Both are readable and writable by the CPU in RUN, and by the host, bypassing RAM.
  - Reading $0001 returns `(DATA & DDR) | (port_in & ~DDR)`.
  - `bank` = `(DATA | ~DDR)[2:0]`, registered.
  - The comparison uses the full 16-bit `ab`, so the port does not mirror.
- Without the macro:
  - $0000 and $0001 are plain RAM.
  - `bank` is tied to 3'b111 and `port_in` is unused.

Decomposition:
- Package `c64_bus_pkg` holds:
  - the state enum `bus_state_t` {CLEAR, RUN, HOST};
  - PORT_DDR_ADDR=16'h0000 and PORT_DATA_ADDR=16'h0001;
  - PORT_DDR_RST=8'h00 and PORT_DATA_RST=8'h37.
- Sub-module `c64_cpu_port` holds the DDR/DATA registers, the read mux term and the `bank` register. It is instantiated only under C64_CPU_PORT_EN.

Test Plan:
- Clear after reset: AW=8, pulse reset for 1 cycle -> `cpu_hold`=1 for exactly 256 cycles, every location reads 8'h00, `cpu_hold`=0 on cycle 257.
- CPU write then read: we=1, ab=16'h0324, cpu_dout=8'h77 -> next cycle, with we=0 and ab=16'h0324, `cpu_din`=8'h77 combinationally.
- Host preload:
  - Stimulus: host_sel=1; beats to addresses 0..5 with data A2 20 A1 40 81 60 and idle gaps; a CPU write to address 2 of 8'hFF during HOST.
  - Response: `load_count`=6, `mem[2]`=8'hA1, the CPU write is ignored, and `cpu_hold` falls one cycle after host_sel=0.
- Processor port (macro on): write $0000=8'h2F, $0001=8'h35, port_in=8'hFF -> reading $0001 returns 8'hF5, `bank`=3'b101. With the macro off, the same writes land in RAM and `bank`=3'b111.
- Reset mid-HOST: assert reset with load_valid=1, load_addr=16'h0010, load_data=8'h55 -> the beat is discarded, the state restarts CLEAR, `load_ready`=0, `load_count`=0.
- Mirroring: AW=12, write 16'h1324=8'h42 -> reading 16'h0324 returns 8'h42.
